// File: rtl/truth_table_sweeper.sv
// ----------------------------------------------------------------------------
// truth_table_sweeper
//
// Sequencer for a 4-input combinational block under test. It drives the
// 16 input combinations A,B,C,D in ascending order to two function
// instances: the original sum-of-minterms form and its simplified
// equivalent. After each vector has had time to settle, it samples both
// outputs. It records the captured truth table of the original function,
// counts the vectors where the two forms disagree, remembers the lowest
// failing vector, and reports pass/fail with a one-cycle done pulse.
//
// Optional feature (compile-time macro GOLDEN_CHECK_EN):
//   When the macro is defined, a vector is also treated as a mismatch when
//   f_orig differs from the GOLDEN parameter bit for that vector. A vector
//   is counted at most once, even if both comparisons fail. When the macro
//   is undefined, only f_orig and f_simp are compared.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..15)
//   STOP_ON_FAIL   1 = end the sweep at the first mismatching vector
//   GOLDEN         expected truth table, bit i = F for vector i
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   sweep request, sampled only while idle
//   abcd          out  vector to both functions (abcd[3]=A .. abcd[0]=D)
//   f_orig        in   original function output
//   f_simp        in   simplified function output
//   busy          out  high from the first APPLY cycle through FINISH
//   done          out  one-cycle pulse in FINISH
//   pass          out  valid after done; 1 when no vector mismatched
//   mismatch_cnt  out  number of mismatching vectors (0..16)
//   first_fail    out  lowest failing vector index
//   fail_seen     out  first_fail holds a valid index
//   truth_table   out  captured f_orig, bit i = vector i
// ----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int          SETTLE_CYCLES = 1,
    parameter bit          STOP_ON_FAIL  = 1'b0,
    parameter logic [15:0] GOLDEN        = 16'hE8F9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  abcd,
    input  logic        f_orig,
    input  logic        f_simp,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail,
    output logic        fail_seen,
    output logic [15:0] truth_table
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        FINISH
    } state_t;

    // The settle counter counts down to zero, so APPLY lasts SETTLE_CYCLES.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       mismatch;

    // abcd doubles as the vector index: it holds the current vector in
    // APPLY and SAMPLE, and it is zero in IDLE.
`ifdef GOLDEN_CHECK_EN
    assign mismatch = (f_orig != f_simp) || (f_orig != GOLDEN[abcd]);
`else
    assign mismatch = (f_orig != f_simp);

    // GOLDEN has no role without the golden comparison.
    logic unused_golden;
    assign unused_golden = ^GOLDEN;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            settle_cnt   <= 4'd0;
            abcd         <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= 5'd0;
            first_fail   <= 4'd0;
            fail_seen    <= 1'b0;
            truth_table  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    abcd <= 4'd0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    // Results of the previous sweep stay visible until the
                    // next accepted start.
                    if (start) begin
                        mismatch_cnt <= 5'd0;
                        fail_seen    <= 1'b0;
                        first_fail   <= 4'd0;
                        truth_table  <= 16'd0;
                        pass         <= 1'b0;
                        settle_cnt   <= SETTLE_LOAD;
                        busy         <= 1'b1;
                        state        <= APPLY;
                    end
                end

                APPLY: begin
                    if (settle_cnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                SAMPLE: begin
                    truth_table[abcd] <= f_orig;
                    if (mismatch) begin
                        // At most 16 increments, so 5 bits never overflow.
                        mismatch_cnt <= mismatch_cnt + 5'd1;
                        if (!fail_seen) begin
                            first_fail <= abcd;
                            fail_seen  <= 1'b1;
                        end
                    end
                    // Vector 15 is always terminal; abcd never wraps.
                    if ((abcd == 4'd15) || (STOP_ON_FAIL && mismatch)) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        abcd       <= abcd + 4'd1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= APPLY;
                    end
                end

                FINISH: begin
                    // mismatch_cnt already includes the final SAMPLE here.
                    pass  <= (mismatch_cnt == 5'd0);
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    abcd  <= 4'd0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
